// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle ARM-style control FSM (fetch/decode/memory/execute/branch)
// Rev 1.0 - initial release
`default_nettype none

module multicycle_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       PCS,
  output logic       InstrDone
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] rd_q, rd_d;

  // Only the immediate flag and the L bit steer the sequence; the opcode field is decoded elsewhere.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        rd_d = Rd;
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      rd_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    MemReq    = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    InstrDone = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        InstrDone = (Op == 2'b11);
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        MemReq    = 1'b1;
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
        InstrDone = MemReady;
      end
      S_EXECR: ALUOp = 1'b1;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_ALUWB: begin
        RegW      = 1'b1;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
    // Rd is taken from the DECODE-cycle copy so later field changes cannot redirect a write to PC.
    PCS = ((rd_q == 4'hF) & RegW) | Branch;
    if (!reset_n) begin
      MemReq    = 1'b0;
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      PCS       = 1'b0;
      InstrDone = 1'b0;
    end
  end

endmodule

`default_nettype wire
